// File: rtl/icache_intc_pkg.sv
// Shared types and helpers for the instruction-cache interconnect:
// bank-index decode, one-hot to index conversion and the round-robin pointer type.
package icache_intc_pkg;

  localparam int unsigned MaxAddrW = 64;
  localparam int unsigned MaxCores = 256;

  typedef logic [MaxAddrW-1:0] addr_wide_t;
  typedef logic [MaxCores-1:0] uid_wide_t;

  // Round-robin priority pointer; wide enough for up to MaxCores requesters.
  typedef logic [7:0] rr_ptr_t;

  // Width of a bank index; a single bank still needs a 1-bit signal.
  function automatic int unsigned bank_idx_width(int unsigned n_banks);
    return (n_banks > 1) ? $clog2(n_banks) : 1;
  endfunction

  // Bank selected by address interleaving at line granularity; 0 for a single bank.
  function automatic int unsigned bank_idx(addr_wide_t addr, int unsigned line_offset,
                                           int unsigned n_banks);
    addr_wide_t shifted;
    shifted = addr >> line_offset;
    return shifted[31:0] & (n_banks - 1);
  endfunction

  function automatic rr_ptr_t onehot_to_idx(uid_wide_t oh);
    rr_ptr_t idx;
    idx = '0;
    for (int unsigned i = 0; i < MaxCores; i++) begin
      if (oh[i]) idx = rr_ptr_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/icache_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the priority pointer,
// wrapping; the pointer moves past the winner only when the grant is accepted.
module icache_rr_arb
  import icache_intc_pkg::*;
#(
  parameter int unsigned N_CORES = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_CORES-1:0] req_i,
  input  logic               accept_i,
  output logic [N_CORES-1:0] gnt_o,
  output logic               valid_o
);

  rr_ptr_t r_ptr;
  rr_ptr_t w_win_idx;
  logic    w_found;

  // Winner search: first pass covers [ptr, N), second pass wraps to [0, ptr).
  always_comb begin
    gnt_o     = '0;
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int unsigned j = 0; j < N_CORES; j++) begin
      if (!w_found && req_i[j] && (rr_ptr_t'(j) >= r_ptr)) begin
        w_found   = 1'b1;
        w_win_idx = rr_ptr_t'(j);
        gnt_o[j]  = 1'b1;
      end
    end
    for (int unsigned j = 0; j < N_CORES; j++) begin
      if (!w_found && req_i[j]) begin
        w_found   = 1'b1;
        w_win_idx = rr_ptr_t'(j);
        gnt_o[j]  = 1'b1;
      end
    end
  end

  assign valid_o = w_found;

  // Priority pointer: advance to the core after the accepted winner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (accept_i && w_found) begin
      r_ptr <= (w_win_idx == rr_ptr_t'(N_CORES - 1)) ? '0 : w_win_idx + rr_ptr_t'(1);
    end
  end

endmodule

// File: rtl/icache_req_router.sv
// Routes core fetch requests to interleaved icache banks with one round-robin arbiter
// per bank, and fans bank responses back to cores by one-hot UID.
// Define ICACHE_REQ_ROUTER_OUT_REG_EN for a registered one-entry output slot per bank.
module icache_req_router
  import icache_intc_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned N_CORES       = 16,
  parameter int unsigned UID_WIDTH     = N_CORES,
  parameter int unsigned N_CACHE_BANKS = 8,
  parameter int unsigned LINE_OFFSET   = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [N_CORES-1:0]                 request_i,
  input  logic [N_CORES*ADDRESS_WIDTH-1:0]   address_i,
  input  logic [N_CORES*UID_WIDTH-1:0]       UID_i,
  output logic [N_CORES-1:0]                 grant_o,
  output logic [N_CACHE_BANKS-1:0]           request_o,
  output logic [N_CACHE_BANKS*ADDRESS_WIDTH-1:0] address_o,
  output logic [N_CACHE_BANKS*UID_WIDTH-1:0] UID_o,
  input  logic [N_CACHE_BANKS-1:0]           grant_i,
  input  logic [N_CACHE_BANKS-1:0]           response_i,
  input  logic [N_CACHE_BANKS*UID_WIDTH-1:0] response_UID_i,
  output logic [N_CORES-1:0]                 response_o
);

  localparam int unsigned BankIdxW = bank_idx_width(N_CACHE_BANKS);

  logic [N_CORES-1:0][BankIdxW-1:0]            w_core_bank;
  logic [N_CACHE_BANKS-1:0][N_CORES-1:0]       w_bank_req;
  logic [N_CACHE_BANKS-1:0][N_CORES-1:0]       w_win;
  logic [N_CACHE_BANKS-1:0]                    w_valid;
  logic [N_CACHE_BANKS-1:0]                    w_can_load;
  logic [N_CACHE_BANKS-1:0]                    w_accept;
  logic [N_CACHE_BANKS-1:0][ADDRESS_WIDTH-1:0] w_sel_addr;
  logic [N_CACHE_BANKS-1:0][UID_WIDTH-1:0]     w_sel_uid;
  logic [N_CORES-1:0][N_CACHE_BANKS-1:0]       w_resp_hits;

  // Decode each core's target bank and present its request to that bank only.
  always_comb begin
    w_core_bank = '0;
    w_bank_req  = '0;
    for (int unsigned c = 0; c < N_CORES; c++) begin
      w_core_bank[c] = BankIdxW'(bank_idx(
          addr_wide_t'(address_i[c*ADDRESS_WIDTH +: ADDRESS_WIDTH]), LINE_OFFSET, N_CACHE_BANKS));
      for (int unsigned b = 0; b < N_CACHE_BANKS; b++) begin
        if (w_core_bank[c] == BankIdxW'(b)) w_bank_req[b][c] = request_i[c];
      end
    end
  end

  for (genvar gb = 0; gb < N_CACHE_BANKS; gb++) begin : g_bank
    icache_rr_arb #(
      .N_CORES(N_CORES)
    ) u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (w_bank_req[gb]),
      .accept_i(w_accept[gb]),
      .gnt_o   (w_win[gb]),
      .valid_o (w_valid[gb])
    );
  end

  // Steer the winning core's address and UID onto each bank.
  always_comb begin
    w_sel_addr = '0;
    w_sel_uid  = '0;
    for (int unsigned b = 0; b < N_CACHE_BANKS; b++) begin
      for (int unsigned c = 0; c < N_CORES; c++) begin
        if (w_win[b][c]) begin
          w_sel_addr[b] = address_i[c*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          w_sel_uid[b]  = UID_i[c*UID_WIDTH +: UID_WIDTH];
        end
      end
    end
  end

`ifdef ICACHE_REQ_ROUTER_OUT_REG_EN
  logic [N_CACHE_BANKS-1:0]                    r_req;
  logic [N_CACHE_BANKS-1:0][ADDRESS_WIDTH-1:0] r_addr;
  logic [N_CACHE_BANKS-1:0][UID_WIDTH-1:0]     r_uid;

  // A slot can take a new request when empty or when its current one drains this cycle.
  assign w_can_load = ~r_req | grant_i;

  // Per-bank output slot: load the arbiter winner, or go empty if nobody is requesting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req  <= '0;
      r_addr <= '0;
      r_uid  <= '0;
    end else begin
      for (int unsigned b = 0; b < N_CACHE_BANKS; b++) begin
        if (w_can_load[b]) begin
          r_req[b] <= w_valid[b];
          if (w_valid[b]) begin
            r_addr[b] <= w_sel_addr[b];
            r_uid[b]  <= w_sel_uid[b];
          end
        end
      end
    end
  end

  assign request_o = r_req;
  assign address_o = r_addr;
  assign UID_o     = r_uid;
`else
  assign w_can_load = grant_i;
  // Hold bank requests off during reset so a bank never accepts one the core will not see.
  assign request_o  = w_valid & {N_CACHE_BANKS{~rst_i}};
  assign address_o  = w_sel_addr;
  assign UID_o      = w_sel_uid;
`endif

  assign w_accept = w_valid & w_can_load & {N_CACHE_BANKS{~rst_i}};

  // A core is granted when it won its bank and that bank takes the request this cycle.
  always_comb begin
    grant_o = '0;
    for (int unsigned b = 0; b < N_CACHE_BANKS; b++) begin
      if (w_accept[b]) grant_o = grant_o | w_win[b];
    end
  end

  // Responses are pure fan-in by UID; no buffering.
  always_comb begin
    response_o = '0;
    for (int unsigned b = 0; b < N_CACHE_BANKS; b++) begin
      if (response_i[b]) response_o = response_o | response_UID_i[b*UID_WIDTH +: UID_WIDTH];
    end
  end

  // Per-core view of which banks are responding to it this cycle.
  always_comb begin
    w_resp_hits = '0;
    for (int unsigned c = 0; c < N_CORES; c++) begin
      for (int unsigned b = 0; b < N_CACHE_BANKS; b++) begin
        w_resp_hits[c][b] = response_i[b] & response_UID_i[b*UID_WIDTH + c];
      end
    end
  end

  for (genvar gc = 0; gc < N_CORES; gc++) begin : g_resp_chk
    a_resp_unique: assert property (@(posedge clk_i) disable iff (rst_i)
                                    $onehot0(w_resp_hits[gc]));
  end

endmodule

// File: tb/tb_icache_req_router.sv
// Bench for icache_req_router (4 cores, 2 banks) plus a 1-core/1-bank instance.
// Follows ICACHE_REQ_ROUTER_OUT_REG_EN to pick the expected timing.
module tb_icache_req_router;

  localparam int unsigned AW = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned NB = 2;
  localparam int unsigned LO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_i;
  logic [NC-1:0]      request_i;
  logic [NC*AW-1:0]   address_i;
  logic [NC*NC-1:0]   UID_i;
  logic [NC-1:0]      grant_o;
  logic [NB-1:0]      request_o;
  logic [NB*AW-1:0]   address_o;
  logic [NB*NC-1:0]   UID_o;
  logic [NB-1:0]      grant_i;
  logic [NB-1:0]      response_i;
  logic [NB*NC-1:0]   response_UID_i;
  logic [NC-1:0]      response_o;

  icache_req_router #(
    .ADDRESS_WIDTH(AW),
    .N_CORES      (NC),
    .UID_WIDTH    (NC),
    .N_CACHE_BANKS(NB),
    .LINE_OFFSET  (LO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .request_i     (request_i),
    .address_i     (address_i),
    .UID_i         (UID_i),
    .grant_o       (grant_o),
    .request_o     (request_o),
    .address_o     (address_o),
    .UID_o         (UID_o),
    .grant_i       (grant_i),
    .response_i    (response_i),
    .response_UID_i(response_UID_i),
    .response_o    (response_o)
  );

  logic          s_req, s_gnt, s_req_o, s_gnt_i, s_resp_i, s_resp_o;
  logic [0:0]    s_uid, s_uid_o, s_resp_uid;
  logic [AW-1:0] s_addr, s_addr_o;

  icache_req_router #(
    .ADDRESS_WIDTH(AW),
    .N_CORES      (1),
    .UID_WIDTH    (1),
    .N_CACHE_BANKS(1),
    .LINE_OFFSET  (LO)
  ) dut_single (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .request_i     (s_req),
    .address_i     (s_addr),
    .UID_i         (s_uid),
    .grant_o       (s_gnt),
    .request_o     (s_req_o),
    .address_o     (s_addr_o),
    .UID_o         (s_uid_o),
    .grant_i       (s_gnt_i),
    .response_i    (s_resp_i),
    .response_UID_i(s_resp_uid),
    .response_o    (s_resp_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus state (what the cores and banks are doing).
  bit            rst;
  logic [NC-1:0] req;
  logic [AW-1:0] addr [NC];
  logic [NB-1:0] gin;
  logic [NB-1:0] rin;
  logic [NC-1:0] ruid [NB];

  // Reference model state.
  int            ptr    [NB];
  bit            slot_v [NB];
  logic [AW-1:0] slot_a [NB];
  logic [NC-1:0] slot_u [NB];

  function automatic int bank_of(logic [AW-1:0] a);
    return int'((a >> LO) % NB);
  endfunction

  // One cycle: drive inputs, compare outputs against the model, then advance the model.
  task automatic step(output logic [NC-1:0] obs_gnt, output logic [NC-1:0] obs_resp);
    int            win  [NB];
    bit            load [NB];
    logic [NC-1:0] exp_gnt;
    logic [NC-1:0] exp_resp;
    @(negedge clk);
    rst_i      = rst;
    request_i  = req;
    grant_i    = gin;
    response_i = rin;
    for (int c = 0; c < NC; c++) begin
      address_i[c*AW +: AW] = addr[c];
      UID_i[c*NC +: NC]     = NC'(1) << c;
    end
    for (int b = 0; b < NB; b++) response_UID_i[b*NC +: NC] = ruid[b];
    #2;
    exp_gnt = '0;
    for (int b = 0; b < NB; b++) begin
      win[b] = -1;
      for (int i = 0; i < NC; i++) begin
        int c;
        c = (ptr[b] + i) % NC;
        if (win[b] < 0 && req[c] && bank_of(addr[c]) == b) win[b] = c;
      end
`ifdef ICACHE_REQ_ROUTER_OUT_REG_EN
      load[b] = !slot_v[b] || gin[b];
      check_eq($sformatf("request_o[%0d]", b), 64'(request_o[b]), 64'(slot_v[b]));
      if (slot_v[b]) begin
        check_eq($sformatf("address_o[%0d]", b), 64'(address_o[b*AW +: AW]), 64'(slot_a[b]));
        check_eq($sformatf("UID_o[%0d]", b), 64'(UID_o[b*NC +: NC]), 64'(slot_u[b]));
      end
`else
      load[b] = gin[b];
      check_eq($sformatf("request_o[%0d]", b), 64'(request_o[b]), 64'(!rst && win[b] >= 0));
      if (!rst && win[b] >= 0) begin
        check_eq($sformatf("address_o[%0d]", b), 64'(address_o[b*AW +: AW]),
                 64'(addr[win[b]]));
        check_eq($sformatf("UID_o[%0d]", b), 64'(UID_o[b*NC +: NC]), 64'(NC'(1) << win[b]));
      end
`endif
      if (!rst && win[b] >= 0 && load[b]) exp_gnt[win[b]] = 1'b1;
    end
    exp_resp = '0;
    for (int b = 0; b < NB; b++) if (rin[b]) exp_resp = exp_resp | ruid[b];
    check_eq("grant_o", 64'(grant_o), 64'(exp_gnt));
    check_eq("response_o", 64'(response_o), 64'(exp_resp));
    obs_gnt  = grant_o;
    obs_resp = response_o;
    @(posedge clk);
    for (int b = 0; b < NB; b++) begin
      if (rst) begin
        ptr[b]    = 0;
        slot_v[b] = 1'b0;
      end else begin
        if (win[b] >= 0 && load[b]) ptr[b] = (win[b] + 1) % NC;
`ifdef ICACHE_REQ_ROUTER_OUT_REG_EN
        if (load[b]) begin
          slot_v[b] = (win[b] >= 0);
          if (win[b] >= 0) begin
            slot_a[b] = addr[win[b]];
            slot_u[b] = NC'(1) << win[b];
          end
        end
`endif
      end
    end
    req = req & ~exp_gnt;
  endtask

  initial begin
    logic [NC-1:0] g;
    logic [NC-1:0] r;
    int            ca;
    int            cb;
    rst = 1'b1; req = '0; gin = '0; rin = '0;
    for (int c = 0; c < NC; c++) addr[c] = '0;
    for (int b = 0; b < NB; b++) begin
      ruid[b] = '0; ptr[b] = 0; slot_v[b] = 1'b0; slot_a[b] = '0; slot_u[b] = '0;
    end
    rst_i = 1'b1; request_i = '0; address_i = '0; UID_i = '0;
    grant_i = '0; response_i = '0; response_UID_i = '0;
    s_req = 1'b0; s_addr = '0; s_uid = 1'b1; s_gnt_i = 1'b0; s_resp_i = 1'b0; s_resp_uid = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state.
    step(g, r);
    check_eq("rst_grant", 64'(g), 64'(0));

    // Single core, single bank.
    @(negedge clk);
    rst_i = 1'b0; rst = 1'b0;
    s_req = 1'b1; s_addr = 32'hdead_beef; s_gnt_i = 1'b1;
    #2;
    check_eq("single_grant", 64'(s_gnt), 64'(1));
`ifdef ICACHE_REQ_ROUTER_OUT_REG_EN
    check_eq("single_req_lat", 64'(s_req_o), 64'(0));
`else
    check_eq("single_req", 64'(s_req_o), 64'(1));
    check_eq("single_addr", 64'(s_addr_o), 64'(32'hdead_beef));
`endif
    @(negedge clk);
    s_req = 1'b0;
    #2;
`ifdef ICACHE_REQ_ROUTER_OUT_REG_EN
    check_eq("single_req_next", 64'(s_req_o), 64'(1));
    check_eq("single_addr_next", 64'(s_addr_o), 64'(32'hdead_beef));
    check_eq("single_uid_next", 64'(s_uid_o), 64'(1));
`else
    check_eq("single_req_idle", 64'(s_req_o), 64'(0));
`endif

    // Interleaved addresses: banks 0,1 serve cores 0,1 then 2,3.
    req = 4'b1111; gin = 2'b11;
    addr[0] = 32'h00; addr[1] = 32'h10; addr[2] = 32'h20; addr[3] = 32'h30;
    step(g, r);
    check_eq("interleave_c0", 64'(g), 64'(4'b0011));
    step(g, r);
    check_eq("interleave_c1", 64'(g), 64'(4'b1100));
    step(g, r);

    // All cores on bank 0, continuous demand: strict rotation.
    rst = 1'b1;
    step(g, r);
    rst = 1'b0; gin = 2'b01;
    addr[0] = 32'h00; addr[1] = 32'h20; addr[2] = 32'h40; addr[3] = 32'h60;
    for (int k = 0; k < 5; k++) begin
      req = 4'b1111;
      step(g, r);
      check_eq($sformatf("rotate_%0d", k), 64'(g), 64'(NC'(1) << (k % NC)));
    end

    // Bank 0 stalled: no grants, pointer must not move.
    gin = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step(g, r);
      check_eq($sformatf("stall_%0d", k), 64'(g), 64'(0));
    end
    gin = 2'b01;
    step(g, r);
    check_eq("stall_resume", 64'(g), 64'(4'b0010));
    gin = 2'b11;
    repeat (4) step(g, r);

    // Simultaneous responses to different cores.
    rin = 2'b11; ruid[1] = 4'b0100; ruid[0] = 4'b0001;
    step(g, r);
    check_eq("resp_pair", 64'(r), 64'(4'b0101));
    rin = 2'b00;

    // Reset with a request in flight, then the first grant goes to core 0.
    req = 4'b1000; gin = 2'b00;
    step(g, r);
    rst = 1'b1;
    step(g, r);
    check_eq("rst_mid_grant", 64'(g), 64'(0));
    rst = 1'b0; req = 4'b1111; gin = 2'b01;
    step(g, r);
    check_eq("post_rst_first", 64'(g), 64'(4'b0001));

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int c = 0; c < NC; c++) begin
        if (!req[c] && $urandom_range(0, 1) == 1) begin
          req[c]  = 1'b1;
          addr[c] = $urandom;
        end
      end
      gin = NB'($urandom);
      rin = NB'($urandom);
      ca  = int'($urandom_range(0, NC - 1));
      cb  = (ca + 1 + int'($urandom_range(0, NC - 2))) % NC;
      ruid[0] = NC'(1) << ca;
      ruid[1] = NC'(1) << cb;
      step(g, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
